// File: rtl/keypad_entry_controller.sv
// Sequencer from keypad key strobes to the password comparator write interface.
// Latency: a key strobed at edge N is acted on at edge N+1; its outputs are visible for one cycle from there.
// Backpressure: none upstream; strobes are dropped while busy is high (init, compare, clear).
module keypad_entry_controller #(
    parameter int NUM_DIGITS = 6,
    parameter int MIN_DIGITS = 4,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic                  lock_correct,
    output logic [3:0]            data,
    output logic [NUM_DIGITS-1:0] cs,
    output logic                  wr,
    output logic [CNT_W-1:0]      digit_count,
    output logic                  compare,
    output logic                  input_clear,
    output logic                  set_mode,
    output logic                  busy,
    output logic                  key_err
);

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef enum logic [2:0] {
        S_INIT,
        S_ENTRY,
        S_WRITE,
        S_CMP_HI,
        S_CLEAR,
        S_SET_ENTRY,
        S_SET_WRITE
    } state_t;

    state_t                  state_q, state_d;
    logic                    kv_q, kv_d;
    logic [3:0]              kc_q, kc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    cmp_second_q, cmp_second_d;
    logic [3:0]              data_q, data_d;
    logic [NUM_DIGITS-1:0]   cs_q, cs_d;
    logic                    wr_q, wr_d;
    logic                    compare_q, compare_d;
    logic                    input_clear_q, input_clear_d;
    logic                    set_mode_q, set_mode_d;
    logic                    busy_q, busy_d;
    logic                    key_err_q, key_err_d;

    logic                    accept;
    logic                    is_digit;
    logic                    has_room;
    logic [NUM_DIGITS-1:0]   slot_onehot;

    assign accept      = kv_q & ~busy_q;
    assign is_digit    = (kc_q <= 4'd9);
    assign has_room    = (count_q < CNT_W'(NUM_DIGITS));
    assign slot_onehot = NUM_DIGITS'(1) << count_q;

    // Next-state and next-output decode; each state's outputs are registered on the edge that enters it.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        cmp_second_d  = 1'b0;
        data_d        = data_q;
        cs_d          = '0;
        wr_d          = 1'b0;
        compare_d     = 1'b0;
        input_clear_d = 1'b0;
        set_mode_d    = set_mode_q;
        busy_d        = 1'b0;
        key_err_d     = 1'b0;
        // A strobe seen while busy is already visible never reaches the FSM.
        kv_d          = key_valid & ~busy_q;
        kc_d          = key_code;

        case (state_q)
            S_INIT: begin
                input_clear_d = 1'b1;
                busy_d        = 1'b1;
                state_d       = S_ENTRY;
            end

            // WRITE only marks the cs cycle; it takes keys exactly like ENTRY so digits can run back-to-back.
            S_ENTRY, S_WRITE: begin
                state_d = S_ENTRY;
                if (accept) begin
                    if (is_digit) begin
                        if (has_room) begin
                            state_d = S_WRITE;
                            data_d  = kc_q;
                            cs_d    = slot_onehot;
                            count_d = count_q + CNT_W'(1);
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end else if (kc_q == KEY_STAR) begin
                        state_d   = S_CMP_HI;
                        compare_d = 1'b1;
                        busy_d    = 1'b1;
                    end else if (kc_q == KEY_HASH) begin
                        if (lock_correct && (count_q == '0)) begin
                            state_d    = S_SET_ENTRY;
                            set_mode_d = 1'b1;
                        end else begin
                            state_d       = S_CLEAR;
                            input_clear_d = 1'b1;
                            busy_d        = 1'b1;
                            count_d       = '0;
                        end
                    end
                end
            end

            // Compare stays high two cycles with digit_count frozen, then the buffer is cleared.
            S_CMP_HI: begin
                busy_d = 1'b1;
                if (!cmp_second_q) begin
                    compare_d    = 1'b1;
                    cmp_second_d = 1'b1;
                end else begin
                    state_d       = S_CLEAR;
                    input_clear_d = 1'b1;
                    count_d       = '0;
                end
            end

            S_CLEAR: begin
                state_d = S_ENTRY;
            end

            S_SET_ENTRY, S_SET_WRITE: begin
                state_d = S_SET_ENTRY;
                if (accept) begin
                    if (is_digit) begin
                        if (has_room) begin
                            state_d = S_SET_WRITE;
                            data_d  = kc_q;
                            cs_d    = slot_onehot;
                            wr_d    = 1'b1;
                            count_d = count_q + CNT_W'(1);
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end else if (kc_q == KEY_STAR) begin
                        if (count_q >= CNT_W'(MIN_DIGITS)) begin
                            state_d       = S_CLEAR;
                            set_mode_d    = 1'b0;
                            input_clear_d = 1'b1;
                            busy_d        = 1'b1;
                            count_d       = '0;
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end else if (kc_q == KEY_HASH) begin
                        key_err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // State, captured key and all registered outputs; reset aborts everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_INIT;
            kv_q          <= 1'b0;
            kc_q          <= 4'd0;
            count_q       <= '0;
            cmp_second_q  <= 1'b0;
            data_q        <= 4'd0;
            cs_q          <= '0;
            wr_q          <= 1'b0;
            compare_q     <= 1'b0;
            input_clear_q <= 1'b0;
            set_mode_q    <= 1'b0;
            busy_q        <= 1'b0;
            key_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            kv_q          <= kv_d;
            kc_q          <= kc_d;
            count_q       <= count_d;
            cmp_second_q  <= cmp_second_d;
            data_q        <= data_d;
            cs_q          <= cs_d;
            wr_q          <= wr_d;
            compare_q     <= compare_d;
            input_clear_q <= input_clear_d;
            set_mode_q    <= set_mode_d;
            busy_q        <= busy_d;
            key_err_q     <= key_err_d;
        end
    end

    assign data        = data_q;
    assign cs          = cs_q;
    assign wr          = wr_q;
    assign digit_count = count_q;
    assign compare     = compare_q;
    assign input_clear = input_clear_q;
    assign set_mode    = set_mode_q;
    assign busy        = busy_q;
    assign key_err     = key_err_q;

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Randomized and directed key sequences checked cycle by cycle against a timeline model.
// The model turns each key strobe into expected output events at absolute cycle numbers.
// Strobes inside the busy window following init, compare or clear are dropped by the model.
module tb_keypad_entry_controller;

    localparam int ND    = 6;
    localparam int MIN   = 4;
    localparam int CW    = 3;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          key_valid = 1'b0;
    logic [3:0]    key_code = 4'd0;
    logic          lock_correct = 1'b0;
    logic [3:0]    data;
    logic [ND-1:0] cs;
    logic          wr;
    logic [CW-1:0] digit_count;
    logic          compare;
    logic          input_clear;
    logic          set_mode;
    logic          busy;
    logic          key_err;

    keypad_entry_controller #(
        .NUM_DIGITS (ND),
        .MIN_DIGITS (MIN),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .lock_correct (lock_correct),
        .data         (data),
        .cs           (cs),
        .wr           (wr),
        .digit_count  (digit_count),
        .compare      (compare),
        .input_clear  (input_clear),
        .set_mode     (set_mode),
        .busy         (busy),
        .key_err      (key_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Expected one-cycle pulses per absolute cycle (cycle k = interval after edge k).
    logic [ND-1:0] e_cs [DEPTH];
    bit            e_wr [DEPTH];
    bit            e_cmp[DEPTH];
    bit            e_clr[DEPTH];
    bit            e_busy[DEPTH];
    bit            e_err[DEPTH];
    // Level outputs change only at recorded cycles.
    bit            ev_dc[DEPTH];
    int            v_dc [DEPTH];
    bit            ev_data[DEPTH];
    int            v_data [DEPTH];
    bit            ev_sm[DEPTH];
    bit            v_sm [DEPTH];
    int            lv_dc, lv_data;
    bit            lv_sm;

    // Abstract entry state.
    int            m_cnt;
    bit            m_set;
    int            blocked_until;
    bit            pend;
    int            pend_m;
    logic [3:0]    pend_code;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            e_cs[i] = '0; e_wr[i] = 0; e_cmp[i] = 0; e_clr[i] = 0; e_busy[i] = 0; e_err[i] = 0;
            ev_dc[i] = 0; v_dc[i] = 0; ev_data[i] = 0; v_data[i] = 0; ev_sm[i] = 0; v_sm[i] = 0;
        end
        lv_dc = 0; lv_data = 0; lv_sm = 0;
        m_cnt = 0; m_set = 0; pend = 0;
        // Power-up clear pulse right after release; strobes on the first two edges are lost.
        e_clr[1] = 1; e_busy[1] = 1;
        blocked_until = 2;
    endtask

    task automatic set_dc(input int k, input int v);
        ev_dc[k] = 1; v_dc[k] = v;
    endtask

    // Strobe taken at edge m; its effects start in cycle m+1. lock_correct is read at edge m+1.
    task automatic model_key(input int m, input logic [3:0] code);
        int e;
        e = m + 1;
        if (m <= blocked_until) return;
        if (code <= 4'd9) begin
            if (m_cnt == ND) begin
                e_err[e] = 1;
            end else begin
                e_cs[e] = ND'(1 << m_cnt);
                e_wr[e] = m_set;
                m_cnt++;
                set_dc(e, m_cnt);
                ev_data[e] = 1; v_data[e] = int'(code);
            end
        end else if (code == 4'd10) begin
            if (!m_set) begin
                e_cmp[e] = 1; e_cmp[e+1] = 1;
                e_busy[e] = 1; e_busy[e+1] = 1; e_busy[e+2] = 1;
                e_clr[e+2] = 1;
                set_dc(e + 2, 0);
                m_cnt = 0;
                blocked_until = m + 4;
            end else if (m_cnt >= MIN) begin
                m_set = 0;
                ev_sm[e] = 1; v_sm[e] = 0;
                e_clr[e] = 1; e_busy[e] = 1;
                set_dc(e, 0);
                m_cnt = 0;
                blocked_until = m + 2;
            end else begin
                e_err[e] = 1;
            end
        end else if (code == 4'd11) begin
            if (m_set) begin
                e_err[e] = 1;
            end else if (lock_correct && m_cnt == 0) begin
                m_set = 1;
                ev_sm[e] = 1; v_sm[e] = 1;
            end else begin
                e_clr[e] = 1; e_busy[e] = 1;
                set_dc(e, 0);
                m_cnt = 0;
                blocked_until = m + 2;
            end
        end
    endtask

    task automatic check_cycle();
        if (ev_dc[cyc])   lv_dc   = v_dc[cyc];
        if (ev_data[cyc]) lv_data = v_data[cyc];
        if (ev_sm[cyc])   lv_sm   = v_sm[cyc];
        chk("cs",          32'(cs),          32'(e_cs[cyc]));
        chk("wr",          32'(wr),          32'(e_wr[cyc]));
        chk("data",        32'(data),        32'(lv_data));
        chk("digit_count", 32'(digit_count), 32'(lv_dc));
        chk("compare",     32'(compare),     32'(e_cmp[cyc]));
        chk("input_clear", 32'(input_clear), 32'(e_clr[cyc]));
        chk("set_mode",    32'(set_mode),    32'(lv_sm));
        chk("busy",        32'(busy),        32'(e_busy[cyc]));
        chk("key_err",     32'(key_err),     32'(e_err[cyc]));
    endtask

    task automatic check_zero();
        chk("rst_cs",   32'(cs), 0);
        chk("rst_wr",   32'(wr), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_dc",   32'(digit_count), 0);
        chk("rst_cmp",  32'(compare), 0);
        chk("rst_clr",  32'(input_clear), 0);
        chk("rst_sm",   32'(set_mode), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err",  32'(key_err), 0);
    endtask

    // One clock: drive, edge, update the model, then sample on the falling edge.
    task automatic step(input logic kv, input logic [3:0] kc);
        key_valid = kv;
        key_code  = kc;
        @(posedge clk);
        cyc++;
        if (pend) model_key(pend_m, pend_code);
        pend = kv; pend_m = cyc; pend_code = kc;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic key(input logic [3:0] kc);
        step(1'b1, kc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0);
    endtask

    // Asynchronous assertion from a falling-edge point: outputs must clear without a clock.
    task automatic do_reset();
        #2;
        reset     = 1'b0;
        key_valid = 1'b0;
        #1;
        check_zero();
        clear_model();
        cyc = 0;
        @(negedge clk);
        @(negedge clk);
        check_zero();
        reset = 1'b1;
    endtask

    initial begin
        int r;
        do_reset();

        // Reset in the middle of a write cycle.
        idle(3);
        key(4'd7);
        idle(1);
        do_reset();

        // Four digits back-to-back, then compare.
        idle(3);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd10);
        idle(8);

        // Seventh digit overflows.
        for (int i = 0; i < 7; i++) key(4'(i + 1));
        idle(2);
        key(4'd10);
        idle(8);

        // Password set: too short, then accepted at four digits.
        lock_correct = 1'b1;
        key(4'd11); idle(1);
        key(4'd9); key(4'd8); key(4'd7); idle(1);
        key(4'd10); idle(1);
        key(4'd11); idle(1);
        key(4'd6); idle(1);
        key(4'd10);
        idle(6);

        // Hash without lock_correct discards the entry.
        lock_correct = 1'b0;
        key(4'd5); key(4'd5); key(4'd11);
        idle(6);

        // Strobe during compare and an ignored code are both dropped.
        key(4'd3); idle(1);
        key(4'd10); idle(1);
        key(4'd5); idle(6);
        key(4'd13); idle(3);
        key(4'd15); key(4'd12); idle(3);

        // Random sessions.
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            idle(3);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 9) == 0) lock_correct = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 99) < 45) begin
                    r = $urandom_range(0, 19);
                    if (r <= 12)      key(4'($urandom_range(0, 9)));
                    else if (r <= 15) key(4'd10);
                    else if (r <= 17) key(4'd11);
                    else              key(4'($urandom_range(12, 15)));
                end else begin
                    idle(1);
                end
            end
            idle(8);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
